// File: rtl/field_pkg.sv
// Shared field-bus definitions: FSM state encoding, line levels and a width helper.
// Used by both the serialiser and the matching deserialiser.
package field_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;
  localparam logic IDLE_LEVEL  = 1'b1;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/field_bit_timer.sv
// Per-bit down-counter: load restarts a bit period, tick marks its last cycle.
module field_bit_timer
  import field_pkg::*;
#(
  parameter int BIT_CYCLES = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic load,
  output logic tick
);

  localparam int TW = cnt_width(BIT_CYCLES);
  localparam logic [TW-1:0] LOAD_VAL = TW'(BIT_CYCLES - 1);

  logic [TW-1:0] cnt_reg;
  logic [TW-1:0] cnt_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = LOAD_VAL;
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - TW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign tick = (cnt_reg == '0);

endmodule

// File: rtl/field_serial_tx.sv
// Field-bus transmitter: start bit, BSIZE data bits LSB-first, optional even parity, stop bit.
// Define FIELD_SERIAL_TX_PARITY_EN to insert the parity bit between data and stop.
module field_serial_tx
  import field_pkg::*;
#(
  parameter int BSIZE      = 3,
  parameter int BIT_CYCLES = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [BSIZE-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx_out,
  output logic             busy,
  output logic             frame_done
);

  localparam int BCW = $clog2(BSIZE + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(BSIZE - 1);

  state_t           state_reg;
  state_t           state_next;
  logic [BSIZE-1:0] shreg_reg;
  logic [BSIZE-1:0] shreg_next;
  logic [BSIZE-1:0] shreg_shifted;
  logic [BCW-1:0]   bit_cnt_reg;
  logic [BCW-1:0]   bit_cnt_next;
  logic             tx_reg;
  logic             tx_next;
  logic             accept;
  logic             tick;
  logic             timer_load;
  logic             parity_bit;

  assign in_ready   = (state_reg == ST_IDLE) && reset_n;
  assign accept     = in_valid && in_ready;
  assign busy       = (state_reg != ST_IDLE);
  assign frame_done = (state_reg == ST_STOP) && tick;
  assign tx_out     = tx_reg;
  // Every bit period restarts on accept and on each tick while a frame runs.
  assign timer_load = accept || (busy && tick);

  field_bit_timer #(
    .BIT_CYCLES(BIT_CYCLES)
  ) u_bit_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .load   (timer_load),
    .tick   (tick)
  );

  generate
    for (genvar gi = 0; gi < BSIZE; gi++) begin : g_shift
      if (gi == BSIZE - 1) begin : g_top
        assign shreg_shifted[gi] = 1'b0;
      end else begin : g_mid
        assign shreg_shifted[gi] = shreg_reg[gi+1];
      end
    end
  endgenerate

`ifdef FIELD_SERIAL_TX_PARITY_EN
  localparam state_t AFTER_DATA = ST_PARITY;
  logic parity_reg;

  // The shift register is consumed bit by bit, so parity is captured at accept.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      parity_reg <= 1'b0;
    end else if (accept) begin
      parity_reg <= ^in_data;
    end
  end
  assign parity_bit = parity_reg;
`else
  localparam state_t AFTER_DATA = ST_STOP;
  assign parity_bit = STOP_LEVEL;
`endif

  always_comb begin
    state_next   = state_reg;
    shreg_next   = shreg_reg;
    bit_cnt_next = bit_cnt_reg;
    tx_next      = IDLE_LEVEL;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_START;
          shreg_next = in_data;
        end
      end
      ST_START: begin
        if (tick) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_next = '0;
            state_next   = AFTER_DATA;
          end else begin
            bit_cnt_next = bit_cnt_reg + BCW'(1);
            shreg_next   = shreg_shifted;
          end
        end
      end
      ST_PARITY: begin
        if (tick) state_next = ST_STOP;
      end
      ST_STOP: begin
        if (tick) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase

    // The line register carries the level of the state being entered.
    case (state_next)
      ST_START:  tx_next = START_LEVEL;
      ST_DATA:   tx_next = shreg_next[0];
      ST_PARITY: tx_next = parity_bit;
      ST_STOP:   tx_next = STOP_LEVEL;
      default:   tx_next = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      shreg_reg   <= '0;
      bit_cnt_reg <= '0;
      tx_reg      <= IDLE_LEVEL;
    end else begin
      state_reg   <= state_next;
      shreg_reg   <= shreg_next;
      bit_cnt_reg <= bit_cnt_next;
      tx_reg      <= tx_next;
    end
  end

endmodule

// File: tb/tb_field_serial_tx.sv
// Scoreboard bench for field_serial_tx: stimulus pushes the expected per-cycle line, a monitor pops.
module tb_field_serial_tx;

  localparam int BSIZE      = 3;
  localparam int BIT_CYCLES = 3;
`ifdef FIELD_SERIAL_TX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int FRAME_LEN = (BSIZE + 2 + PAR_BITS) * BIT_CYCLES;

  logic             clock    = 1'b0;
  logic             reset_n  = 1'b0;
  logic [BSIZE-1:0] in_data  = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             tx_out;
  logic             busy;
  logic             frame_done;

  typedef struct packed {
    logic tx;
    logic done;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  always #5 clock = ~clock;

  field_serial_tx #(
    .BSIZE     (BSIZE),
    .BIT_CYCLES(BIT_CYCLES)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .tx_out    (tx_out),
    .busy      (busy),
    .frame_done(frame_done)
  );

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endfunction

  // Reference frame: start, data LSB first, optional even parity, stop; each bit BIT_CYCLES long.
  task automatic push_frame(input logic [BSIZE-1:0] d);
    logic bits[$];
    exp_t e;
    bits.push_back(1'b0);
    for (int i = 0; i < BSIZE; i++) bits.push_back(d[i]);
    if (PAR_BITS == 1) bits.push_back(logic'($countones(d) % 2));
    bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      for (int c = 0; c < BIT_CYCLES; c++) begin
        e.tx   = bits[b];
        e.done = (b == bits.size() - 1) && (c == BIT_CYCLES - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // Offers one field and returns just after the accepting edge.
  task automatic send(input logic [BSIZE-1:0] d);
    int waited;
    bit got;
    waited   = 0;
    got      = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    while (!got && waited <= 2 * FRAME_LEN + 10) begin
      @(negedge clock);
      if (in_ready) got = 1'b1;
      else waited++;
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout data=%b: in_ready stayed 0, expected 1 within %0d cycles",
               d, 2 * FRAME_LEN + 10);
      in_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1;
      push_frame(d);
      in_valid = 1'b0;
      $display("tx frame data=%b accepted at %0t", d, $time);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4 * FRAME_LEN) begin
      @(posedge clock);
      n++;
    end
    #1;
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    $display("reset pulse at %0t", $time);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    logic exp_rdy;
    if (mon_en) begin
      exp_rdy = reset_n && (exp_q.size() == 0);
      check("in_ready", in_ready, exp_rdy);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tx_out", tx_out, e.tx);
        check("frame_done", frame_done, e.done);
        check("busy", busy, 1'b1);
      end else begin
        check("idle_tx_out", tx_out, 1'b1);
        check("idle_busy", busy, 1'b0);
        check("idle_frame_done", frame_done, 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [BSIZE-1:0] d;
    int gap;
    // Reset held three edges with a field offered: nothing may be accepted.
    reset_n  = 1'b0;
    in_valid = 1'b1;
    in_data  = 3'b101;
    @(posedge clock);
    #1;
    mon_en = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset_n  = 1'b1;
    in_valid = 1'b0;
    repeat (5) @(posedge clock);
    #1;

    send(3'b101);
    wait_idle();

    send(3'b000);
    send(3'b111);
    wait_idle();

    send(3'b001);
    wait_idle();

    send(3'b011);
    wait_idle();

    // Abort during the first data bit.
    send(3'b110);
    repeat (BIT_CYCLES) @(posedge clock);
    #1;
    reset_pulse();
    repeat (3) @(posedge clock);
    #1;

    for (int i = 0; i < 40; i++) begin
      d = BSIZE'($urandom);
      send(d);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, FRAME_LEN - 1)) @(posedge clock);
        #1;
        reset_pulse();
      end
      gap = $urandom_range(0, 3);
      if (gap != 0) begin
        wait_idle();
        repeat (gap) @(posedge clock);
        #1;
      end
    end
    wait_idle();
    repeat (3) @(posedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
